fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end between the PC-select path and the IF/ID buffer.
- Generates sequential fetch addresses and issues them to instruction memory over a req/ready handshake.
- Collects in-order responses into a DEPTH-entry queue and presents {pc, inst} to IF/ID with valid/stall flow control.
- On a taken branch/jump it flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, queue entries and the maximum number of outstanding memory requests; power of 2, at least 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.
PC_STEP, 1, increment added to the fetch PC per accepted request (word-addressed instruction memory).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
in_redirect  in  1  taken branch/jump from PC control, valid for one cycle.
in_redirect_pc  in  32  target address; sampled when in_redirect=1.
out_imem_req  out  1  fetch request valid.
out_imem_addr  out  32  fetch address; held stable while out_imem_req=1 and in_imem_ready=0.
in_imem_ready  in  1  memory accepts the request this cycle.
in_imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
in_imem_rdata  in  32  instruction word.
in_stall  in  1  IF/ID hold; the head entry is not consumed.
out_valid  out  1  queue head valid.
out_pc  out  32  PC of the head instruction.
out_inst  out  32  head instruction; opcode is bits [31:28].

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC; queue count, rd/wr pointers, outstanding and drop_cnt all 0.
  - Outputs during and after reset: out_valid=0, out_imem_req=0, out_pc=0, out_inst=0.
  - A reset mid-operation discards all state. Responses arriving after reset are ignored only while drop_cnt>0; since drop_cnt is 0 after reset, the memory must also be reset.
- Request issue (combinational):
  - out_imem_req = !rst & !in_redirect & (outstanding < DEPTH) & (count + (outstanding - drop_cnt) < DEPTH). This credit rule guarantees every live response has a queue slot.
  - out_imem_addr = fetch_pc.
- Request accepted (req & ready): fetch_pc += PC_STEP (32-bit wrap, 32'hFFFF_FFFF+1 -> 0); outstanding += 1.
- Response (rvalid):
  - outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and the data is discarded.
  - Otherwise enqueue {pc_tag, rdata}. pc_tag comes from an internal tag FIFO written at acceptance, or equivalently from resp_pc incremented per live response.
- Dequeue: out_valid & !in_stall -> rd_ptr += 1. out_pc/out_inst are driven from the head register, so there is no combinational path from rdata.
- Latency: request accepted at cycle t, rvalid at t+1 -> out_valid=1 at t+2. Steady-state throughput is 1 instruction/cycle when ready=1, rvalid has 1-cycle latency, and no stall.
- Full: count==DEPTH -> no enqueue can occur (guaranteed by credit); req=0.
- Empty: out_valid=0; out_pc/out_inst hold their last values.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Redirect (in_redirect=1 at posedge):
  - Queue flushed (count=0, pointers equal); out_valid=0 next cycle.
  - fetch_pc=in_redirect_pc; no request is issued in the redirect cycle.
  - drop_cnt = outstanding - (rvalid ? 1 : 0). The rvalid in the same cycle belongs to the old stream and is discarded.
  - A dequeue in the same cycle still completes (IF/ID captures it); the flush takes precedence over any enqueue.
  - Back-to-back redirects: the latest target wins; drop_cnt is recomputed each time.
- New requests may issue while drop_cnt>0; in-order return keeps the dropped responses first.
- rst has priority over in_redirect.

Optional Feature:
- Macro FETCH_QUEUE_PERF_EN.
- Defined: adds output ports out_perf_flush (16) and out_perf_stall (16).
  - out_perf_flush counts redirects.
  - out_perf_stall counts cycles with out_valid & in_stall.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; the rest of the block's behaviour is identical.

Test Plan:
- Reset, then ready=1 and rvalid 1 cycle after acceptance, stall=0 -> addresses 0,1,2,3...; first out_valid 2 cycles after the first acceptance, out_pc=0, then 1,2,3 on consecutive cycles.
- Hold in_stall=1 with ready=1 -> exactly 4 requests accepted, then req=0. count=4, out_pc stays 0. Release the stall -> entries drain 0..3 and requests resume at address 4.
- With 3 requests outstanding (addr 8,9,10) assert in_redirect with pc=0x40, in the same cycle as the rvalid for 8 -> drop_cnt=2. The responses for 9 and 10 are discarded; the first out_pc after the redirect is 0x40.
- in_imem_ready=0 for 5 cycles -> out_imem_addr is held at the same value and fetch_pc does not advance.
- Redirect to 32'hFFFF_FFFF -> the next fetch addresses are FFFF_FFFF then 0000_0000.
- FETCH_QUEUE_PERF_EN defined: 3 redirects and 7 stalled-valid cycles -> out_perf_flush=3, out_perf_stall=7; asserting rst clears both to 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a DEPTH-entry in-order response queue and redirect flush.
// Define FETCH_QUEUE_PERF_EN to add saturating redirect and stalled-valid counters.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_redirect,
    input  logic [31:0] in_redirect_pc,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ready,
    input  logic        in_imem_rvalid,
    input  logic [31:0] in_imem_rdata,
    input  logic        in_stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0] out_perf_flush,
    output logic [15:0] out_perf_stall
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    logic [31:0]   fetch_pc, resp_pc, head_pc, head_inst;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0] count, outstanding, drop_cnt, count_nxt;
    logic [63:0]   mem [DEPTH];
    logic          acc, enq, deq, head_from_rdata;
    // Credit counts queued entries plus live in-flight requests so every live response has a slot.
    always_comb begin
        out_imem_req    = !rst && !in_redirect && outstanding < CW'(DEPTH)
                          && count + outstanding - drop_cnt < CW'(DEPTH);
        out_imem_addr   = fetch_pc;
        out_valid       = !rst && count != '0;
        out_pc          = rst ? '0 : head_pc;
        out_inst        = rst ? '0 : head_inst;
        acc             = out_imem_req && in_imem_ready;
        enq             = in_imem_rvalid && drop_cnt == '0 && !in_redirect;
        deq             = out_valid && !in_stall;
        rd_nxt          = rd_ptr + AW'(deq);
        count_nxt       = in_redirect ? '0 : count + CW'(enq) - CW'(deq);
        head_from_rdata = count == CW'(deq);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            head_pc     <= '0;
            head_inst   <= '0;
        end else begin
            fetch_pc    <= in_redirect ? in_redirect_pc : fetch_pc + (acc ? PC_STEP : '0);
            resp_pc     <= in_redirect ? in_redirect_pc : resp_pc + (enq ? PC_STEP : '0);
            outstanding <= outstanding + CW'(acc) - CW'(in_imem_rvalid);
            drop_cnt    <= in_redirect ? outstanding - CW'(in_imem_rvalid)
                                       : drop_cnt - CW'(in_imem_rvalid && drop_cnt != '0);
            count       <= count_nxt;
            rd_ptr      <= in_redirect ? '0 : rd_nxt;
            wr_ptr      <= in_redirect ? '0 : wr_ptr + AW'(enq);
            // Head register tracks the next head so outputs never depend combinationally on rdata.
            if (count_nxt != '0)
                {head_pc, head_inst} <= head_from_rdata ? {resp_pc, in_imem_rdata} : mem[rd_nxt];
        end
    end
    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= {resp_pc, in_imem_rdata};
    end
`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_perf_flush <= '0;
            out_perf_stall <= '0;
        end else begin
            if (in_redirect && out_perf_flush != 16'hFFFF)
                out_perf_flush <= out_perf_flush + 16'd1;
            if (out_valid && in_stall && out_perf_stall != 16'hFFFF)
                out_perf_stall <= out_perf_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_redirect = 0;
    logic [31:0] in_redirect_pc = 0;
    logic        out_imem_req;
    logic [31:0] out_imem_addr;
    logic        in_imem_ready = 1;
    logic        in_imem_rvalid = 0;
    logic [31:0] in_imem_rdata = 0;
    logic        in_stall = 0;
    logic        out_valid;
    logic [31:0] out_pc, out_inst;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] perf_flush, perf_stall;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'd1)) dut (
        .clk(clk), .rst(rst), .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc),
        .out_imem_req(out_imem_req), .out_imem_addr(out_imem_addr), .in_imem_ready(in_imem_ready),
        .in_imem_rvalid(in_imem_rvalid), .in_imem_rdata(in_imem_rdata), .in_stall(in_stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst)
`ifdef FETCH_QUEUE_PERF_EN
        , .out_perf_flush(perf_flush), .out_perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
    typedef struct {logic [31:0] pc; bit stale;} fl_t;
    typedef struct {logic [31:0] addr; int due;} mr_t;
    typedef struct {logic rst, stall, ready, e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc;} vec_t;

    ent_t fifo[$];
    fl_t  infl[$];
    mr_t  mq[$];
    logic [31:0] m_pc = 0, last_pc = 0, last_inst = 0;
    int   cyc = 0, mem_lat_max = 0, n_vec = 0, n_mis = 0;
    bit   mem_hold = 0;
    logic e_req, e_valid, s_req, s_valid;
    logic [31:0] e_pc, e_inst, s_addr, s_pc, s_inst;
    vec_t tbl[19];

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive memory response, compare at negedge, advance model at posedge.
    task automatic cycle();
        int live;
        fl_t f;
        if (!mem_hold && !rst && mq.size() != 0 && mq[0].due <= cyc) begin
            in_imem_rvalid = 1;
            in_imem_rdata  = inst_of(mq[0].addr);
        end else begin
            in_imem_rvalid = 0;
            in_imem_rdata  = $urandom;
        end
        live = 0;
        foreach (infl[i]) if (!infl[i].stale) live++;
        e_req   = !rst && !in_redirect && infl.size() < DEPTH && fifo.size() + live < DEPTH;
        e_valid = !rst && fifo.size() != 0;
        e_pc    = rst ? 32'h0 : (fifo.size() != 0 ? fifo[0].pc : last_pc);
        e_inst  = rst ? 32'h0 : (fifo.size() != 0 ? fifo[0].inst : last_inst);
        @(negedge clk);
        s_req = out_imem_req; s_addr = out_imem_addr; s_valid = out_valid; s_pc = out_pc; s_inst = out_inst;
        chk("req", s_req, e_req);
        chk("addr", s_addr, m_pc);
        chk("valid", s_valid, e_valid);
        chk("pc", s_pc, e_pc);
        chk("inst", s_inst, e_inst);
        @(posedge clk);
        if (rst) begin
            fifo.delete(); infl.delete(); mq.delete();
            m_pc = 0; last_pc = 0; last_inst = 0;
        end else begin
            if (e_valid && !in_stall) void'(fifo.pop_front());
            if (in_imem_rvalid) begin
                void'(mq.pop_front());
                if (infl.size() != 0) begin
                    f = infl.pop_front();
                    if (!f.stale && !in_redirect) fifo.push_back('{f.pc, in_imem_rdata});
                end
            end
            if (in_redirect) begin
                fifo.delete();
                foreach (infl[i]) infl[i].stale = 1;
                m_pc = in_redirect_pc;
            end else if (e_req && in_imem_ready) begin
                infl.push_back('{m_pc, 1'b0});
                mq.push_back('{m_pc, cyc + 1 + int'($urandom_range(mem_lat_max, 0))});
                m_pc = m_pc + 32'd1;
            end
            if (fifo.size() != 0) begin last_pc = fifo[0].pc; last_inst = fifo[0].inst; end
        end
        cyc++;
        #1;
    endtask

    task automatic reset_seq();
        rst = 1; in_redirect = 0; in_stall = 0; in_imem_ready = 1; mem_hold = 0;
        cycle(); cycle();
        rst = 0;
    endtask

    initial begin
        bit found;
        logic [31:0] a0;
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 2, 1, 0};
        tbl[4]  = '{0, 1, 1, 1, 3, 1, 0};
        tbl[5]  = '{0, 1, 1, 0, 4, 1, 0};
        tbl[6]  = '{0, 1, 1, 0, 4, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 4, 1, 0};
        tbl[8]  = '{0, 0, 1, 1, 4, 1, 1};
        tbl[9]  = '{0, 0, 1, 1, 5, 1, 2};
        tbl[10] = '{0, 0, 1, 1, 6, 1, 3};
        tbl[11] = '{0, 0, 1, 1, 7, 1, 4};
        tbl[12] = '{0, 0, 1, 1, 8, 1, 5};
        tbl[13] = '{1, 0, 1, 0, 9, 0, 0};
        tbl[14] = '{1, 0, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 1, 1, 0, 0};
        tbl[17] = '{0, 0, 1, 1, 2, 1, 0};
        tbl[18] = '{0, 0, 1, 1, 3, 1, 1};
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; in_stall = tbl[i].stall; in_imem_ready = tbl[i].ready;
            cycle();
            chk($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_inst", i), s_inst, inst_of(tbl[i].e_pc));
        end

        // Redirect while 8,9,10 are in flight, coinciding with the response for 8.
        reset_seq();
        in_redirect = 1; in_redirect_pc = 32'h8; cycle(); in_redirect = 0;
        mem_hold = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("drop_issue_addr", s_addr, 32'h8 + 32'(i));
        end
        in_imem_ready = 0; mem_hold = 0;
        in_redirect = 1; in_redirect_pc = 32'h40; cycle(); in_redirect = 0;
        chk("drop_same_rvalid", in_imem_rvalid, 1);
        chk("drop_req_in_redirect", s_req, 0);
        in_imem_ready = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = s_valid;
        end
        chk("drop_found_valid", found, 1);
        chk("drop_first_pc", s_pc, 32'h40);
        chk("drop_first_inst", s_inst, inst_of(32'h40));

        // Memory not ready: address held, fetch PC does not advance.
        in_imem_ready = 0; cycle(); a0 = s_addr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_addr", s_addr, a0);
            chk("hold_req", s_req, 1);
        end
        in_imem_ready = 1; cycle(); cycle();
        chk("hold_resume_addr", s_addr, a0 + 32'd1);

        // 32-bit wrap of the fetch address.
        in_redirect = 1; in_redirect_pc = 32'hFFFF_FFFF; cycle(); in_redirect = 0;
        cycle(); chk("wrap_addr0", s_addr, 32'hFFFF_FFFF); chk("wrap_req0", s_req, 1);
        cycle(); chk("wrap_addr1", s_addr, 32'h0);
        repeat (4) cycle();

`ifdef FETCH_QUEUE_PERF_EN
        reset_seq();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = s_valid;
        end
        in_stall = 1; repeat (7) cycle(); in_stall = 0;
        in_redirect = 1;
        for (int i = 0; i < 3; i++) begin in_redirect_pc = 32'h100 * 32'(i + 1); cycle(); end
        in_redirect = 0; cycle();
        chk("perf_flush", perf_flush, 3);
        chk("perf_stall", perf_stall, 7);
        rst = 1; cycle(); rst = 0;
        chk("perf_flush_rst", perf_flush, 0);
        chk("perf_stall_rst", perf_stall, 0);
`endif

        // Random traffic with variable memory latency.
        reset_seq();
        mem_lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rst            = $urandom_range(199, 0) == 0;
            in_redirect    = $urandom_range(19, 0) == 0;
            in_redirect_pc = $urandom_range(1, 0) != 0 ? $urandom : 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
            in_stall       = $urandom_range(9, 0) < 3;
            in_imem_ready  = $urandom_range(9, 0) < 7;
            mem_hold       = $urandom_range(7, 0) == 0;
            cycle();
        end
        rst = 0; in_redirect = 0; mem_hold = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
